// File: rtl/skew_loader.sv
// -----------------------------------------------------------------------------
// skew_loader
//   Upstream controller for the skew buffer. It accepts one ARRAY_SIZE-wide
//   A-matrix vector per valid/ready handshake and writes it straight into the
//   skew buffer at an incrementing row pointer. Once a full tile has been
//   loaded, it drains the buffer into the systolic array: 2*ARRAY_SIZE-1
//   enabled beats, each gated by array_ready. A one-cycle tile_done pulse
//   follows the final beat.
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   flush          synchronous abort of the current tile
//   in_valid       upstream vector valid
//   in_ready       loader can accept a vector
//   in_data        one A vector (ARRAY_SIZE signed elements)
//   buf_write      skew buffer write strobe (same-edge as handshake)
//   buf_enable     skew buffer read/shift strobe
//   buf_row_ptr    skew buffer target row
//   buf_data       vector to skew buffer (in_data passed through unchanged)
//   out_valid      skew buffer outputs hold a valid wavefront beat
//   array_ready    systolic array consumes the beat this cycle
//   out_last       current beat is the final drain beat
//   tile_done      one-cycle pulse after the last drain beat
//   busy           not idle (state is not LOAD, or a partial tile is held)
//   tile_count     number of completed tiles, wraps at 2^16
// -----------------------------------------------------------------------------
module skew_loader #(
   parameter int ARRAY_SIZE = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [DATA_WIDTH-1:0] in_data [ARRAY_SIZE],
   output logic                         buf_write,
   output logic                         buf_enable,
   output logic [$clog2(ARRAY_SIZE)-1:0] buf_row_ptr,
   output logic signed [DATA_WIDTH-1:0] buf_data [ARRAY_SIZE],
   output logic                         out_valid,
   input  logic                         array_ready,
   output logic                         out_last,
   output logic                         tile_done,
   output logic                         busy,
   output logic [15:0]                  tile_count
);

   localparam int RW  = $clog2(ARRAY_SIZE);
   localparam int DCW = $clog2(2 * ARRAY_SIZE);

   localparam logic [RW-1:0]  ROW_LAST   = RW'(ARRAY_SIZE - 1);
   localparam logic [DCW-1:0] DRAIN_LAST = DCW'(2 * ARRAY_SIZE - 2);

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t         state;
   logic [RW-1:0]  row_cnt;
   logic [DCW-1:0] drain_cnt;

   // Strobes are decoded from the registered state so the skew buffer can
   // sample the write on the same edge as the handshake.
   assign buf_data    = in_data;
   assign buf_row_ptr = row_cnt;
   assign in_ready    = (state == LOAD);
   assign buf_write   = in_valid & in_ready & ~flush;
   assign out_valid   = (state == DRAIN);
   assign buf_enable  = out_valid & array_ready & ~flush;
   assign out_last    = out_valid & (drain_cnt == DRAIN_LAST);
   assign tile_done   = (state == DONE);
   assign busy        = (state != LOAD) || (row_cnt != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= LOAD;
         row_cnt    <= '0;
         drain_cnt  <= '0;
         tile_count <= '0;
      end else if (flush) begin
         // Abort wins over any handshake or drain beat in the same cycle;
         // tile_count is left untouched.
         state     <= LOAD;
         row_cnt   <= '0;
         drain_cnt <= '0;
      end else begin
         case (state)
            LOAD: begin
               if (in_valid) begin
                  if (row_cnt == ROW_LAST) begin
                     row_cnt <= '0;
                     state   <= DRAIN;
                  end else begin
                     row_cnt <= row_cnt + RW'(1);
                  end
               end
            end
            DRAIN: begin
               if (array_ready) begin
                  if (drain_cnt == DRAIN_LAST) begin
                     drain_cnt <= '0;
                     state     <= DONE;
                  end else begin
                     drain_cnt <= drain_cnt + DCW'(1);
                  end
               end
            end
            DONE: begin
               tile_count <= tile_count + 16'd1;
               state      <= LOAD;
            end
            default: begin
               state <= LOAD;
            end
         endcase
      end
   end

endmodule

// File: doc/skew_loader.md
Name: skew_loader

Overview:
- Upstream controller for the skew buffer. Accepts one ARRAY_SIZE-wide A-matrix vector per valid/ready handshake and writes it into the skew buffer at an incrementing row pointer.
- After a full tile (ARRAY_SIZE vectors) it drains the buffer into the systolic array: one buffer enable per accepted beat, 2*ARRAY_SIZE-1 beats total.
- Applies backpressure on both sides and reports tile completion.

Parameters:
- ARRAY_SIZE, 8, systolic array dimension; must be a power of two, at least 2.
- DATA_WIDTH, 8, signed element width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort of the current tile.
- in_valid  in  1  upstream vector valid.
- in_ready  out  1  loader can accept a vector.
- in_data  in  ARRAY_SIZE x DATA_WIDTH (signed, unpacked)  one A vector.
- buf_write  out  1  skew buffer write strobe.
- buf_enable  out  1  skew buffer read/shift strobe.
- buf_row_ptr  out  $clog2(ARRAY_SIZE)  skew buffer target row.
- buf_data  out  ARRAY_SIZE x DATA_WIDTH (signed, unpacked)  vector to skew buffer.
- out_valid  out  1  skew buffer outputs hold a valid wavefront beat.
- array_ready  in  1  systolic array consumes the beat this cycle.
- out_last  out  1  current beat is the final drain beat.
- tile_done  out  1  one-cycle pulse after the last drain beat.
- busy  out  1  state is not LOAD, or row_cnt is not 0.
- tile_count  out  16  number of completed tiles, wraps at 2^16.

Behaviour:
- States: LOAD, DRAIN, DONE.
- Counters:
  - row_cnt, $clog2(ARRAY_SIZE) bits.
  - drain_cnt, $clog2(2*ARRAY_SIZE) bits.
- Reset (rst_n low, asynchronous) forces:
  - state=LOAD, row_cnt=0, drain_cnt=0, tile_count=0.
  - Combinational outputs therefore read: in_ready=1, buf_write=0, buf_enable=0, out_valid=0, out_last=0, tile_done=0, busy=0, buf_row_ptr=0.
- Combinational outputs:
  - buf_data = in_data.
  - buf_row_ptr = row_cnt.
  - in_ready = (state==LOAD).
  - buf_write = in_valid & in_ready & ~flush.
  - out_valid = (state==DRAIN).
  - buf_enable = out_valid & array_ready & ~flush.
  - out_last = out_valid & (drain_cnt==2*ARRAY_SIZE-2).
  - tile_done = (state==DONE).
- Write latency: zero. The skew buffer samples the write on the same edge as the handshake. No registering of in_data.
- LOAD:
  - On each accepted vector, row_cnt increments.
  - Accepting with row_cnt==ARRAY_SIZE-1 sets row_cnt to 0 and moves to DRAIN on the next edge.
- DRAIN:
  - Each beat with buf_enable high increments drain_cnt.
  - A beat with buf_enable and out_last both high sets drain_cnt to 0 and moves to DONE.
  - array_ready low stalls: drain_cnt holds, and buf_enable stays low.
- DONE: lasts exactly one cycle; tile_count increments; returns to LOAD. in_ready is 0 in DONE.
- Drain length is exactly 2*ARRAY_SIZE-1 enabled beats per tile, independent of stall pattern.
- flush, sampled in any state:
  - Next state is LOAD; row_cnt and drain_cnt are cleared.
  - tile_count and tile_done are not affected: no pulse, no increment.
  - flush has priority over a simultaneous handshake or drain beat, which are suppressed.
- in_valid during DRAIN or DONE is ignored (in_ready=0). The upstream must hold data per valid/ready rules.
- Element order: buf_data passes in_data unchanged. The reversal and skew are performed inside the skew buffer.
- A partial tile (fewer than ARRAY_SIZE vectors) waits in LOAD indefinitely. Only flush or reset clears it.
- Reset mid-DRAIN aborts the tile with no tile_done pulse.

Test Plan (ARRAY_SIZE=4):
- Reset, then 4 back-to-back vectors with array_ready=1:
  - buf_write high 4 cycles with buf_row_ptr 0,1,2,3.
  - Then out_valid for 7 cycles, out_last on the 7th, tile_done 1 cycle later.
  - tile_count=1.
- Drain with array_ready toggling 1,0,1,0,…: exactly 7 buf_enable pulses, out_last coincides with the 7th, and drain_cnt holds during each 0.
- in_valid gaps during LOAD (pattern 1,0,0,1,1,0,1): row_ptr advances only on handshakes, and DRAIN is entered after the 4th.
- Assert flush after 2 vectors:
  - Next cycle row_cnt=0 and state is LOAD.
  - The next vector is written at row_ptr 0.
  - No tile_done, tile_count unchanged.
- Drop rst_n low during DRAIN beat 3: all outputs go to reset values immediately (asynchronous), tile_count=0, in_ready=1.
- Two tiles back-to-back, with in_valid held high through DRAIN: in_ready=0 during DRAIN/DONE, the 2nd tile starts the cycle after tile_done, and tile_count ends at 2.
